// File: rtl/peak_dpu_pkg.sv
// Shared DPU definitions: issue-queue sizing and the decoded packet layout
// used by decode, the issue queue and dispatch.
package peak_dpu_pkg;

    localparam int unsigned DPU_IQ_DEPTH = 4;
    localparam int unsigned DPU_IQ_PW    = 2;
    localparam int unsigned DPU_PKT_W    = 64;

    // Packet field offsets (LSB of each field)
    localparam int unsigned DPU_PKT_PC_LSB      = 0;
    localparam int unsigned DPU_PKT_CLS_LSB     = 32;
    localparam int unsigned DPU_PKT_RD_LSB      = 36;
    localparam int unsigned DPU_PKT_RD_VLD_BIT  = 41;
    localparam int unsigned DPU_PKT_RS1_LSB     = 42;
    localparam int unsigned DPU_PKT_RS1_VLD_BIT = 47;
    localparam int unsigned DPU_PKT_RS2_LSB     = 48;
    localparam int unsigned DPU_PKT_RS2_VLD_BIT = 53;
    localparam int unsigned DPU_PKT_IMM_LSB     = 54;

    // Decoded packet; field order mirrors the offsets above (MSB first)
    typedef struct packed {
        logic [9:0]  imm;
        logic        rs2_vld;
        logic [4:0]  rs2;
        logic        rs1_vld;
        logic [4:0]  rs1;
        logic        rd_vld;
        logic [4:0]  rd;
        logic [3:0]  cls;
        logic [31:0] pc;
    } dpu_pkt_t;

endpackage

// File: rtl/peak_dpu_iss_queue_if.sv
// Decode/dispatch-facing signal bundle of the issue queue.
interface peak_dpu_iss_queue_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned PW = 2
);
    logic          dec_instr0_vld;
    logic [DW-1:0] dec_instr0_data;
    logic          dec_instr1_vld;
    logic [DW-1:0] dec_instr1_data;
    logic          dec_rdy;
    logic          instr0_vld;
    logic [DW-1:0] instr0_data;
    logic          instr1_vld;
    logic [DW-1:0] instr1_data;
    logic          instr0_cannot_iss;
    logic          instr1_cannot_iss;
    logic [PW:0]   iq_cnt;
    logic          iq_empty;

    // Decode and dispatch side (drives packets and verdicts)
    modport master (
        output dec_instr0_vld, dec_instr0_data, dec_instr1_vld, dec_instr1_data,
        output instr0_cannot_iss, instr1_cannot_iss,
        input  dec_rdy, instr0_vld, instr0_data, instr1_vld, instr1_data,
        input  iq_cnt, iq_empty
    );

    // Issue queue side
    modport slave (
        input  dec_instr0_vld, dec_instr0_data, dec_instr1_vld, dec_instr1_data,
        input  instr0_cannot_iss, instr1_cannot_iss,
        output dec_rdy, instr0_vld, instr0_data, instr1_vld, instr1_data,
        output iq_cnt, iq_empty
    );
endinterface

// File: rtl/peak_dpu_iq_ram.sv
// Issue-queue storage: two write ports at consecutive slots, two async
// read ports at consecutive slots. Contents are not reset.
module peak_dpu_iq_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 64,
    parameter int unsigned PW    = 2
) (
    input  logic          clk,
    input  logic          we0,
    input  logic          we1,
    input  logic [PW-1:0] wr_ptr,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    input  logic [PW-1:0] rd_ptr,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr1;
    logic [PW-1:0] rd_ptr1;

    // Second port addresses wrap modulo DEPTH
    always_comb begin
        wr_ptr1 = wr_ptr + PW'(1);
        rd_ptr1 = rd_ptr + PW'(1);
    end

    // Write slot 0 at wr_ptr and slot 1 at the next entry
    always_ff @(posedge clk) begin
        if (we0) mem[wr_ptr]  <= wd0;
        if (we1) mem[wr_ptr1] <= wd1;
    end

    // Asynchronous reads of the two oldest entries
    always_comb begin
        rd0 = mem[rd_ptr];
        rd1 = mem[rd_ptr1];
    end
endmodule

// File: rtl/peak_dpu_iss_queue.sv
// Dual-issue in-order instruction queue between decode and dispatch.
// Accepts up to two packets per cycle, presents the two oldest, and
// retires 0/1/2 per cycle from dispatch's cannot-issue verdicts.
module peak_dpu_iss_queue
    import peak_dpu_pkg::*;
#(
    parameter int unsigned DEPTH = DPU_IQ_DEPTH,
    parameter int unsigned DW    = DPU_PKT_W,
    parameter int unsigned PW    = DPU_IQ_PW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    peak_dpu_iss_queue_if.slave  iq
);
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          dec_rdy;
    logic          instr0_vld;
    logic          instr1_vld;
    logic          we0, we1;
    logic          pop0, pop1;
    logic [1:0]    push_n, pop_n;

    // Handshake, presentation and push/pop decode; dec_rdy uses only the
    // registered count so cannot_iss never reaches decode combinationally
    always_comb begin
        dec_rdy    = (cnt_q <= (PW+1)'(DEPTH - 2));
        instr0_vld = (cnt_q != '0) && !flush;
        instr1_vld = (cnt_q >= (PW+1)'(2)) && !flush;
        we0        = dec_rdy && !flush && iq.dec_instr0_vld;
        we1        = we0 && iq.dec_instr1_vld;
        pop0       = instr0_vld && !iq.instr0_cannot_iss;
        pop1       = pop0 && instr1_vld && !iq.instr1_cannot_iss;
        push_n     = {1'b0, we0} + {1'b0, we1};
        pop_n      = {1'b0, pop0} + {1'b0, pop1};
    end

    // Next pointers and count; flush overrides push and pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            wr_ptr_d = wr_ptr_q + PW'(push_n);
            cnt_d    = cnt_q + (PW+1)'(push_n) - (PW+1)'(pop_n);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    peak_dpu_iq_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .PW    (PW)
    ) u_ram (
        .clk    (clk),
        .we0    (we0),
        .we1    (we1),
        .wr_ptr (wr_ptr_q),
        .wd0    (iq.dec_instr0_data),
        .wd1    (iq.dec_instr1_data),
        .rd_ptr (rd_ptr_q),
        .rd0    (iq.instr0_data),
        .rd1    (iq.instr1_data)
    );

    assign iq.dec_rdy    = dec_rdy;
    assign iq.instr0_vld = instr0_vld;
    assign iq.instr1_vld = instr1_vld;
    assign iq.iq_cnt     = cnt_q;
    assign iq.iq_empty   = (cnt_q == '0);

    // Decode protocol checks: slot 1 alone, or pushing while not ready
    a_slot1_alone: assert property (@(posedge clk) disable iff (!rst_n)
        !(iq.dec_instr1_vld && !iq.dec_instr0_vld))
        else $warning("iss_queue: dec_instr1_vld without dec_instr0_vld ignored");

    a_push_not_rdy: assert property (@(posedge clk) disable iff (!rst_n)
        !(iq.dec_instr0_vld && !dec_rdy && !flush))
        else $warning("iss_queue: push while dec_rdy=0 dropped");
endmodule

// File: tb/tb_peak_dpu_iss_queue.sv
// Bench for peak_dpu_iss_queue: directed scenarios then random traffic,
// all checked against a FIFO model held in a queue.
module tb_peak_dpu_iss_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 64;
    localparam int unsigned PW    = 2;

    logic clk;
    logic rst_n;
    logic flush;

    peak_dpu_iss_queue_if #(.DW(DW), .PW(PW)) iq_if ();

    peak_dpu_iss_queue #(.DEPTH(DEPTH), .DW(DW), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .iq    (iq_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [DW-1:0] model [$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check against model, advance model
    task automatic cyc(input bit i0v, input logic [DW-1:0] d0,
                       input bit i1v, input logic [DW-1:0] d1,
                       input bit c0, input bit c1, input bit fl);
        bit rdy, v0, v1, p0, p1;
        int sz;
        @(negedge clk);
        iq_if.dec_instr0_vld    = i0v;
        iq_if.dec_instr0_data   = d0;
        iq_if.dec_instr1_vld    = i1v;
        iq_if.dec_instr1_data   = d1;
        iq_if.instr0_cannot_iss = c0;
        iq_if.instr1_cannot_iss = c1;
        flush                   = fl;
        #1;
        sz  = model.size();
        rdy = (sz <= DEPTH - 2);
        v0  = (sz >= 1) && !fl;
        v1  = (sz >= 2) && !fl;
        chk("dec_rdy",    DW'(iq_if.dec_rdy),    DW'(rdy));
        chk("iq_cnt",     DW'(iq_if.iq_cnt),     DW'(sz));
        chk("iq_empty",   DW'(iq_if.iq_empty),   DW'(sz == 0));
        chk("instr0_vld", DW'(iq_if.instr0_vld), DW'(v0));
        chk("instr1_vld", DW'(iq_if.instr1_vld), DW'(v1));
        if (v0) chk("instr0_data", iq_if.instr0_data, model[0]);
        if (v1) chk("instr1_data", iq_if.instr1_data, model[1]);
        if (fl) begin
            model.delete();
        end else begin
            p0 = v0 && !c0;
            p1 = p0 && v1 && !c1;
            if (p0) void'(model.pop_front());
            if (p1) void'(model.pop_front());
            if (rdy && i0v) begin
                model.push_back(d0);
                if (i1v) model.push_back(d1);
            end
        end
    endtask

    task automatic idle(input bit c0, input bit c1);
        cyc(1'b0, '0, 1'b0, '0, c0, c1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] a, b;
        bit i0v, i1v, c0, c1, fl;
        rst_n = 1'b0;
        flush = 1'b0;
        iq_if.dec_instr0_vld    = 1'b0;
        iq_if.dec_instr0_data   = '0;
        iq_if.dec_instr1_vld    = 1'b0;
        iq_if.dec_instr1_data   = '0;
        iq_if.instr0_cannot_iss = 1'b0;
        iq_if.instr1_cannot_iss = 1'b0;
        #12;
        chk("rst_cnt",   DW'(iq_if.iq_cnt),     '0);
        chk("rst_rdy",   DW'(iq_if.dec_rdy),    DW'(1));
        chk("rst_empty", DW'(iq_if.iq_empty),   DW'(1));
        chk("rst_v0",    DW'(iq_if.instr0_vld), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);

        // Single push then issue
        cyc(1'b1, 64'hAAAA_0001, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Dual push, split issue, then a second pair behind the survivor
        cyc(1'b1, 64'hAAAA_0002, 1'b1, 64'hBBBB_0002, 1'b1, 1'b1, 1'b0);
        idle(1'b0, 1'b1);
        cyc(1'b1, 64'hCCCC_0002, 1'b1, 64'hDDDD_0002, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        drain();

        // Fill to DEPTH, dropped push when full, then drain across the wrap
        cyc(1'b1, 64'hAAAA_0003, 1'b1, 64'hBBBB_0003, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 64'hCCCC_0003, 1'b1, 64'hDDDD_0003, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 64'hEEEE_0003, 1'b1, 64'hFFFF_0003, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        drain();

        // Simultaneous push 2 / pop 2 at cnt=2
        cyc(1'b1, 64'hAAAA_0004, 1'b1, 64'hBBBB_0004, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 64'hCCCC_0004, 1'b1, 64'hDDDD_0004, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        drain();

        // Flush at cnt=3 with a concurrent push
        cyc(1'b1, 64'hAAAA_0005, 1'b1, 64'hBBBB_0005, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 64'hCCCC_0005, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 64'hDDDD_0005, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b1);
        cyc(1'b1, 64'hEEEE_0005, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // Asynchronous reset mid-stream
        cyc(1'b1, 64'hAAAA_0006, 1'b1, 64'hBBBB_0006, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 64'hCCCC_0006, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        iq_if.dec_instr0_vld = 1'b0;
        iq_if.dec_instr1_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", DW'(iq_if.iq_cnt),     '0);
        chk("arst_rdy", DW'(iq_if.dec_rdy),    DW'(1));
        chk("arst_v0",  DW'(iq_if.instr0_vld), '0);
        chk("arst_v1",  DW'(iq_if.instr1_vld), '0);
        model.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) idle(1'b0, 1'b0);

        // Random traffic; decode honours dec_rdy as the protocol requires
        for (int i = 0; i < 3000; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            i0v = ($urandom_range(3) != 0) && (model.size() <= DEPTH - 2);
            i1v = i0v && $urandom_range(1);
            c0  = ($urandom_range(3) == 0);
            c1  = ($urandom_range(2) == 0);
            fl  = ($urandom_range(31) == 0);
            cyc(i0v, a, i1v, b, c0, c1, fl);
        end
        idle(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop guard
    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/peak_dpu_iss_queue.md
Name: peak_dpu_iss_queue

Overview:
- Dual-issue instruction queue between decode and the dispatch hazard/forwarding control.
- Accepts up to two decoded instruction packets per cycle from decode.
- Presents the two oldest entries to dispatch as instr0 (older) and instr1 (younger).
- Retires 0, 1 or 2 entries per cycle, based on the cannot-issue verdicts that dispatch returns.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 4.
- DW, 64, width of one decoded packet (pc, opcode class flags, register addresses/valids, immediate).
- PW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (branch mispredict/exception); empties the queue.
- dec_instr0_vld  in  1  decode slot 0 packet valid (older).
- dec_instr0_data  in  DW  decode slot 0 packet.
- dec_instr1_vld  in  1  decode slot 1 packet valid (younger); legal only when dec_instr0_vld=1.
- dec_instr1_data  in  DW  decode slot 1 packet.
- dec_rdy  out  1  queue can accept two packets this cycle.
- instr0_vld  out  1  oldest entry valid.
- instr0_data  out  DW  oldest entry.
- instr1_vld  out  1  second-oldest entry valid.
- instr1_data  out  DW  second-oldest entry.
- instr0_cannot_iss  in  1  dispatch verdict for instr0.
- instr1_cannot_iss  in  1  dispatch verdict for instr1; already includes instr0 blocking.
- iq_cnt  out  PW+1  current occupancy.
- iq_empty  out  1  iq_cnt==0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: rd_ptr=0, wr_ptr=0, cnt=0. Storage array is not reset.
- Outputs after reset: dec_rdy=1, instr0_vld=0, instr1_vld=0, iq_cnt=0, iq_empty=1.
- dec_rdy = (cnt <= DEPTH-2). It is based on the registered count only and is not pop-aware, so there is no combinational path from cannot_iss to decode.
- Push count:
  - push = dec_rdy & ~flush & dec_instr0_vld ? (dec_instr1_vld ? 2 : 1) : 0.
  - dec_instr0 writes to wr_ptr; dec_instr1 writes to wr_ptr+1 (mod DEPTH).
  - wr_ptr advances by push.
- Ignored pushes:
  - dec_instr1_vld without dec_instr0_vld is a protocol error. The packet is ignored and flagged by an assertion.
  - A push while dec_rdy=0 is dropped. Decode must hold its packets; this is also flagged by an assertion.
- Presentation:
  - instr0_vld = (cnt>=1) & ~flush; instr1_vld = (cnt>=2) & ~flush.
  - instr0_data = mem[rd_ptr]; instr1_data = mem[rd_ptr+1] (mod DEPTH). Reads are asynchronous.
  - Data is undefined when the corresponding vld=0.
- Pop count:
  - pop0 = instr0_vld & ~instr0_cannot_iss; pop1 = pop0 & instr1_vld & ~instr1_cannot_iss.
  - pop = pop0 + pop1. Issue is strictly in order: instr1 never issues alone.
- Latency: a packet pushed at edge N is visible on instr0/instr1 from cycle N+1. There is no bypass.
- Count update: cnt_next = cnt + push - pop. A simultaneous push and pop in the same cycle is legal.
- Pointer wrap: pointers wrap modulo DEPTH, with no explicit full flag; the invariant is cnt <= DEPTH.
- Full and empty:
  - cnt=DEPTH: dec_rdy=0; pops continue normally.
  - cnt=DEPTH-1: dec_rdy=0.
  - cnt=0: instr0_vld=0 and no pop occurs; a push in the same cycle becomes visible next cycle.
  - cnt=1: instr1_vld=0; only pop0 is possible.
- Flush:
  - Takes priority over push and pop. Next state: rd_ptr=wr_ptr=0, cnt=0.
  - Packets offered by decode in the flush cycle are discarded.
- Reset mid-operation: all pointers and the count clear immediately. Outputs return to their reset values without waiting for a clock edge.

Decomposition:
- Shared package/header peak_dpu_pkg: DPU_IQ_DEPTH, DPU_IQ_PW, DPU_PKT_W, and the packet field offsets (class flags, rd/rs addresses and valids) that decode and dispatch already share.
- One sub-module: peak_dpu_iq_ram, a DEPTH x DW array with 2 write ports (wr_ptr, wr_ptr+1) and 2 asynchronous read ports (rd_ptr, rd_ptr+1).
- Pointer, count and pop logic stay in peak_dpu_iss_queue.

Test Plan:
- Reset then idle: release rst_n with no decode traffic -> dec_rdy=1, iq_cnt=0, iq_empty=1, instr0_vld=instr1_vld=0 on every cycle.
- Single push: push A (dec_instr0 only) at cycle 1, instr0_cannot_iss=0 -> cycle 2 instr0_vld=1, instr0_data=A, instr1_vld=0; cycle 3 iq_cnt=0.
- Dual push with split issue: push A,B; cycle 2 instr0_cannot_iss=0, instr1_cannot_iss=1 -> cycle 3 instr0_data=B, iq_cnt=1. Then push C,D -> cycle 4 instr0=B, instr1=C, iq_cnt=3.
- Fill and wrap: hold both cannot_iss=1 and push pairs until iq_cnt=4 -> dec_rdy=0 at cnt>=3, and a further push is dropped with iq_cnt staying 4. Then release: 2 pops per cycle return A,B then C,D in order, across the pointer wrap.
- Simultaneous push and pop at cnt=2: push 2 and pop 2 in the same cycle -> iq_cnt stays 2; next instr0/instr1 are the newly pushed packets.
- Flush and reset: with iq_cnt=3, assert flush together with a valid dec push -> instr vlds are 0 in the flush cycle, the next cycle has iq_cnt=0, and the pushed packet is absent. Pull rst_n low mid-stream -> iq_cnt=0 and dec_rdy=1 before the next edge.
